aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
- Iterative AES-128 encryption controller that sequences one shared, combinational round datapath (SubBytes/ShiftRows/MixColumnsXOR plus key expansion) through NR rounds, one round per clock.
- Performs the initial AddRoundKey on load.
- Supplies per-round state, round key, Rcon and a last-round flag that bypasses MixColumns.
- Wraps the round in a valid/ready handshake toward the top level.

Parameters:
- NR, 10: number of rounds. Legal range 1..10. Rcon follows the AES xtime sequence.
- RCON_INIT, 8'h01: Rcon value used in round 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  block_in/key_in are valid.
- in_ready  out  1  sequencer can accept a block. Combinational: high iff FSM is IDLE.
- block_in  in  128  plaintext, byte 0 in [127:120].
- key_in  in  128  cipher key, same byte order.
- rd_state  out  128  current state to datapath (registered).
- rd_key  out  128  current round key to datapath (registered).
- rd_rcon  out  8  Rcon for the key expansion of this round (registered).
- rd_last  out  1  final round, so the datapath skips MixColumns. Equals (FSM==ROUND && round==NR).
- rd_state_next  in  128  datapath result: [MixColumns unless rd_last](ShiftRows(SubBytes(rd_state))) XOR rd_key_next.
- rd_key_next  in  128  datapath key expansion of rd_key using rd_rcon.
- out_valid  out  1  block_out holds the ciphertext.
- out_ready  in  1  consumer accepts block_out.
- block_out  out  128  ciphertext; aliases rd_state.
- busy  out  1  FSM != IDLE.
- round_idx  out  4  current round number, 0 in IDLE.

Behaviour:
- Reset (reset_n low, asynchronous):
  - FSM=IDLE, state_reg=0, key_reg=0, rcon=RCON_INIT, round=0, out_valid=0.
  - in_ready=1 and busy=0 while reset is asserted.
  - Reset mid-operation abandons the block silently; nothing is emitted.
- IDLE:
  - Accept on the edge where in_valid && in_ready.
  - On accept: state_reg <= block_in ^ key_in; key_reg <= key_in; rcon <= RCON_INIT; round <= 1; go to ROUND.
- ROUND, each cycle:
  - state_reg <= rd_state_next; key_reg <= rd_key_next; rcon <= xtime(rcon) = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 0); round <= round+1.
  - When round==NR, the same edge goes to DONE and sets out_valid<=1. round_idx holds NR in DONE.
  - Rcon seen on rd_rcon for rounds 1..10: 01,02,04,08,10,20,40,80,1b,36.
- DONE:
  - out_valid=1; block_out and all registers are held stable while out_ready=0.
  - On the edge with out_ready=1: out_valid<=0, round<=0, go to IDLE.
  - in_ready=0 in DONE, so there is no same-cycle reload.
- Latency:
  - out_valid rises NR clocks after the accept edge.
  - Minimum block period is NR+2 clocks when out_ready is tied high.
- in_valid during ROUND/DONE is ignored; in_ready=0, no state change.
- out_ready while not out_valid is ignored.
- rd_state_next/rd_key_next are sampled only in ROUND. The datapath must settle within one clock.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_valid exactly 10 clocks after accept, block_out = 3925841d02dc09fbdc118597196a0b32.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> block_out = 69c4e0d86a7b0430d8cdb78070b4c55a. Monitor rd_rcon = 01,02,04,08,10,20,40,80,1b,36 and rd_last high only in round 10.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid, block_out stable; in_ready=0. Raise out_ready -> IDLE next edge, in_ready=1.
- in_valid held high with changing data during rounds 1..10 -> only the first block is processed. Second accept occurs exactly 1 cycle after the DONE handshake.
- Reset in round 5 (reset_n low mid-cycle) -> out_valid=0, round_idx=0, busy=0, in_ready=1 immediately. The next App. B run after release produces the correct ciphertext.
- Back-to-back: two vectors, out_ready tied 1 -> results in order, 12-clock spacing between accepts.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 round sequencer: drives one shared combinational round datapath
// through NR rounds, one round per clock, behind a valid/ready handshake.
module aes_round_sequencer #(
    parameter int         NR        = 10,
    parameter logic [7:0] RCON_INIT = 8'h01
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] block_in,
    input  logic [127:0] key_in,
    output logic [127:0] rd_state,
    output logic [127:0] rd_key,
    output logic [7:0]   rd_rcon,
    output logic         rd_last,
    input  logic [127:0] rd_state_next,
    input  logic [127:0] rd_key_next,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] block_out,
    output logic         busy,
    output logic [3:0]   round_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    localparam logic [3:0] NR_L = 4'(NR);

    fsm_t         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   round_q, round_d;
    logic         out_valid_q, out_valid_d;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            key_q       <= '0;
            rcon_q      <= RCON_INIT;
            round_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            key_q       <= key_d;
            rcon_q      <= rcon_d;
            round_q     <= round_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        key_d       = key_q;
        rcon_d      = rcon_q;
        round_d     = round_q;
        out_valid_d = out_valid_q;
        case (fsm_q)
            IDLE: begin
                // Load performs the initial AddRoundKey so round 1 starts on whitened data.
                if (in_valid) begin
                    state_d = block_in ^ key_in;
                    key_d   = key_in;
                    rcon_d  = RCON_INIT;
                    round_d = 4'd1;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                state_d = rd_state_next;
                key_d   = rd_key_next;
                rcon_d  = xtime(rcon_q);
                // The round counter stops at NR so round_idx reports NR while the result waits.
                if (round_q == NR_L) begin
                    fsm_d       = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    round_d     = 4'd0;
                    fsm_d       = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign in_ready  = (fsm_q == IDLE);
    assign busy      = (fsm_q != IDLE);
    assign rd_state  = state_q;
    assign rd_key    = key_q;
    assign rd_rcon   = rcon_q;
    assign rd_last   = (fsm_q == ROUND) && (round_q == NR_L);
    assign out_valid = out_valid_q;
    assign block_out = state_q;
    assign round_idx = round_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer: an AES round datapath model feeds the DUT,
// and an independent whole-block AES-128 model supplies the expected ciphertexts.
module tb_aes_round_sequencer;

    localparam int  NR     = 10;
    localparam time PERIOD = 10;

    logic         clock;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] block_in;
    logic [127:0] key_in;
    logic [127:0] rd_state;
    logic [127:0] rd_key;
    logic [7:0]   rd_rcon;
    logic         rd_last;
    logic [127:0] rd_state_next;
    logic [127:0] rd_key_next;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] block_out;
    logic         busy;
    logic [3:0]   round_idx;

    int           compared   = 0;
    int           mismatched = 0;
    logic [127:0] expQ[$];
    time          lastAccept = 0;
    logic         prevOutValid = 1'b0;
    logic [7:0]   rconTable [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                     8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    aes_round_sequencer #(.NR(NR), .RCON_INIT(8'h01)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .block_in      (block_in),
        .key_in        (key_in),
        .rd_state      (rd_state),
        .rd_key        (rd_key),
        .rd_rcon       (rd_rcon),
        .rd_last       (rd_last),
        .rd_state_next (rd_state_next),
        .rd_key_next   (rd_key_next),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .block_out     (block_out),
        .busy          (busy),
        .round_idx     (round_idx)
    );

    initial clock = 1'b0;
    always #(PERIOD / 2) clock = ~clock;

    // GF(2^8) arithmetic and the AES byte transforms, shared by datapath and reference.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0]  r = 8'h01;
        logic [7:0]  base = x;
        logic [15:0] d;
        int          e = 254;
        while (e != 0) begin
            if (e[0]) r = gmul(r, base);
            base = gmul(base, base);
            e = e >> 1;
        end
        if (x == 8'h00) r = 8'h00;
        d = {r, r};
        return r ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
    endfunction

    function automatic logic [7:0] getB(input logic [127:0] s, input int i);
        return s[127 - 8*i -: 8];
    endfunction

    function automatic logic [127:0] subShift(input logic [127:0] s);
        logic [127:0] o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = sbox(getB(s, 4*((c + r) % 4) + r));
        return o;
    endfunction

    function automatic logic [127:0] mixCols(input logic [127:0] s);
        logic [127:0] o = '0;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = getB(s, 4*c); a1 = getB(s, 4*c + 1);
            a2 = getB(s, 4*c + 2); a3 = getB(s, 4*c + 3);
            o[127 - 32*c -: 32] = {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                                   a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
                                   a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
                                   gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
        end
        return o;
    endfunction

    function automatic logic [31:0] subRotWord(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] dpKeyExp(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = subRotWord(k[31:0]) ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Whole-block reference: full key schedule first, then NR rounds on a local state.
    function automatic logic [127:0] refEncrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc = 8'h01;
        logic [127:0] s;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = subRotWord(t) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        s = pt ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r <= NR; r++) begin
            s = subShift(s);
            if (r != NR) s = mixCols(s);
            s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return s;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Round datapath the sequencer drives.
    always_comb begin
        rd_key_next   = dpKeyExp(rd_key, rd_rcon);
        rd_state_next = subShift(rd_state);
        if (!rd_last) rd_state_next = mixCols(rd_state_next);
        rd_state_next = rd_state_next ^ rd_key_next;
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: event did not occur within its bound", name);
    endtask

    task automatic printSummary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    endtask

    // Issue one block and record its expected result at the accept edge.
    task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] exp);
        int n = 0;
        @(posedge clock); #1;
        block_in = pt; key_in = key; in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        if (!in_ready) failNow("accept_timeout");
        else begin
            expQ.push_back(exp);
            @(posedge clock);
            lastAccept = $time;
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic waitDrain(input bit randomReady);
        int n = 0;
        while (expQ.size() != 0 && n < 500) begin
            @(posedge clock); #1;
            if (randomReady) out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        if (expQ.size() != 0) begin
            failNow("drain_timeout");
            expQ.delete();
        end
        out_ready = 1'b1;
    endtask

    // Monitor: scoreboard pops on every output handshake, plus per-round sideband checks.
    always @(negedge clock) begin
        if (reset_n) begin
            if (out_valid && !prevOutValid)
                checkOutput("latency", 128'(($time - PERIOD/2 - lastAccept) / PERIOD), 128'(NR));
            if (busy && !out_valid) begin
                if (round_idx >= 4'd1 && int'(round_idx) <= NR) begin
                    checkOutput("rd_rcon", 128'(rd_rcon), 128'(rconTable[int'(round_idx) - 1]));
                    checkOutput("rd_last", 128'(rd_last), 128'(int'(round_idx) == NR));
                end else begin
                    failNow("round_idx_range");
                end
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) failNow("unexpected_output");
                else checkOutput("block_out", block_out, expQ.pop_front());
            end
        end
        prevOutValid = reset_n ? out_valid : 1'b0;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        mismatched++;
        printSummary();
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] held, pt, key;
        time          t1, t2;
        int           n;

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        block_in = '0; key_in = '0;
        #12;
        checkOutput("rst_in_ready", 128'(in_ready), 128'(1));
        checkOutput("rst_busy", 128'(busy), 128'(0));
        checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
        checkOutput("rst_round_idx", 128'(round_idx), 128'(0));
        checkOutput("rst_rd_state", rd_state, '0);
        checkOutput("rst_rd_key", rd_key, '0);
        checkOutput("rst_rd_rcon", 128'(rd_rcon), 128'(8'h01));
        @(negedge clock); reset_n = 1'b1;

        $display("[TB] FIPS-197 App. B and C vectors");
        applyStimulus(PT_B, KEY_B, CT_B);
        waitDrain(1'b0);
        applyStimulus(PT_C, KEY_C, CT_C);
        waitDrain(1'b0);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        pt = rand128(); key = rand128();
        applyStimulus(pt, key, refEncrypt(pt, key));
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (!out_valid) failNow("bp_valid_timeout");
        held = block_out;
        repeat (5) begin
            @(posedge clock); #1;
            checkOutput("bp_out_valid", 128'(out_valid), 128'(1));
            checkOutput("bp_block_out", block_out, held);
            checkOutput("bp_in_ready", 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        checkOutput("bp_release_in_ready", 128'(in_ready), 128'(1));
        checkOutput("bp_release_out_valid", 128'(out_valid), 128'(0));
        checkOutput("bp_release_round_idx", 128'(round_idx), 128'(0));

        $display("[TB] in_valid held with changing data");
        pt = rand128(); key = rand128();
        block_in = pt; key_in = key; in_valid = 1'b1;
        expQ.push_back(refEncrypt(pt, key));
        @(posedge clock);
        lastAccept = $time;
        t1 = $time;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            block_in = rand128(); key_in = rand128();
            @(posedge clock); #1;
            n++;
        end
        if (!in_ready) failNow("held_reaccept_timeout");
        pt = rand128(); key = rand128();
        block_in = pt; key_in = key;
        expQ.push_back(refEncrypt(pt, key));
        @(posedge clock);
        lastAccept = $time;
        t2 = $time;
        #1;
        in_valid = 1'b0;
        checkOutput("held_accept_spacing", 128'((t2 - t1) / PERIOD), 128'(NR + 2));
        waitDrain(1'b0);

        $display("[TB] reset in round 5");
        applyStimulus(PT_B, KEY_B, CT_B);
        n = 0;
        while (round_idx != 4'd5 && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (round_idx != 4'd5) failNow("round5_timeout");
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 128'(out_valid), 128'(0));
        checkOutput("midrst_round_idx", 128'(round_idx), 128'(0));
        checkOutput("midrst_busy", 128'(busy), 128'(0));
        checkOutput("midrst_in_ready", 128'(in_ready), 128'(1));
        void'(expQ.pop_back());
        @(negedge clock); reset_n = 1'b1;
        applyStimulus(PT_B, KEY_B, CT_B);
        waitDrain(1'b0);

        $display("[TB] back-to-back with out_ready tied high");
        out_ready = 1'b1;
        applyStimulus(PT_B, KEY_B, CT_B);
        t1 = lastAccept;
        applyStimulus(PT_C, KEY_C, CT_C);
        t2 = lastAccept;
        checkOutput("b2b_accept_spacing", 128'((t2 - t1) / PERIOD), 128'(NR + 2));
        waitDrain(1'b0);

        $display("[TB] randomized blocks with random backpressure");
        repeat (8) begin
            pt = rand128(); key = rand128();
            applyStimulus(pt, key, refEncrypt(pt, key));
            waitDrain(1'b1);
        end

        repeat (3) @(posedge clock);
        printSummary();
        $finish;
    end

endmodule
